// File: rtl/seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_pkg                                                            |
// | Shared character codes and display constants for the 7-seg path.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package seg_pkg;

    localparam int CHAR_W = 4;

    typedef logic [CHAR_W-1:0] char_t;

    localparam char_t CHAR_ONE = 4'd0;
    localparam char_t CHAR_O   = 4'd1;
    localparam char_t CHAR_P   = 4'd2;
    localparam char_t CHAR_R   = 4'd3;

    localparam logic [3:0] AN_OFF = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/seg_scan_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_scan_timer                                                     |
// | Step prescaler and 4-bit {digit, step} scan position counter.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module seg_scan_timer #(
    parameter int PRESCALE = 16
) (
    input  logic       clk,
    input  logic       reset,
    output logic       step_tick,
    output logic [1:0] digit,
    output logic [1:0] step,
    output logic       frame_end
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] r_presc;
    logic [3:0]    r_pos;

    assign step_tick = (r_presc == PW'(PRESCALE - 1));
    assign digit     = r_pos[3:2];
    assign step      = r_pos[1:0];
    assign frame_end = step_tick && (r_pos == 4'hF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_pos   <= 4'd0;
        end else begin
            if (step_tick) begin
                r_presc <= '0;
                r_pos   <= r_pos + 4'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_scan_scheduler                                                 |
// | Anode/character scan with per-digit blanking and message scroll.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module seg_scan_scheduler
    import seg_pkg::*;
#(
    parameter int PRESCALE      = 16,
    parameter int BLANK_STEPS   = 1,
    parameter int MSG_LEN       = 8,
    parameter int SCROLL_PERIOD = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  char_t                      wr_data,
    input  logic                       scroll_en,
    output logic [3:0]                 an,
    output char_t                      char,
    output logic                       frame_tick,
    output logic [$clog2(MSG_LEN)-1:0] win_pos
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int FW = (SCROLL_PERIOD > 1) ? $clog2(SCROLL_PERIOD) : 1;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic          w_step_tick;
    logic          w_frame_end;
    logic [1:0]    w_digit;
    logic [1:0]    w_step;
    logic [0:0]    w_state;
    logic [AW-1:0] w_rd_addr;
    logic          w_unused_tick;

    char_t         r_buf [MSG_LEN];
    logic [FW-1:0] r_frame_cnt;
    logic [AW-1:0] r_win_pos;
    logic [3:0]    r_an;
    char_t         r_char;
    logic          r_frame_tick;

    seg_scan_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .step_tick (w_step_tick),
        .digit     (w_digit),
        .step      (w_step),
        .frame_end (w_frame_end)
    );

    // Step sequencing is fully captured by frame_end and the scan position.
    assign w_unused_tick = w_step_tick;

    assign w_state   = ({1'b0, w_step} < 3'(BLANK_STEPS)) ? ST_BLANK : ST_DRIVE;
    assign w_rd_addr = r_win_pos + AW'(w_digit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                r_buf[i] <= char_t'(i % 4);
            end
        end else if (wr_en) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // Window moves on the same edge the scan wraps, so every frame reads one window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_win_pos   <= '0;
        end else if (w_frame_end && scroll_en) begin
            if (r_frame_cnt == FW'(SCROLL_PERIOD - 1)) begin
                r_frame_cnt <= '0;
                r_win_pos   <= r_win_pos + AW'(1);
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an         <= AN_OFF;
            r_char       <= CHAR_ONE;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
            if (w_state == ST_DRIVE) begin
                r_an   <= ~(4'b1000 >> w_digit);
                r_char <= r_buf[w_rd_addr];
            end else begin
                r_an   <= AN_OFF;
            end
        end
    end

    assign an         = r_an;
    assign char       = r_char;
    assign frame_tick = r_frame_tick;
    assign win_pos    = r_win_pos;

endmodule
`default_nettype wire
